ir_reflect_emitter: RTL
=======================

Name: ir_reflect_emitter

Overview:
- Transmit side of the line-sensor channel: pulses the IR emitter LED and samples the phototransistor return in LED-on and LED-off phases.
- Reports a reflection decision per measurement; the on/off comparison rejects ambient light.
- Sits between the sensor pad and the steering logic.
- Its detect output is the per-channel input to the downstream noise filter.

Parameters:
- SETTLE_CYCLES, 50: cycles spent in each settle phase before sampling; covers LED rise/fall time and synchronizer delay.
- SAMPLE_CYCLES, 16: cycles counted in each sample phase.
- THRESHOLD, 12: minimum (on_cnt - off_cnt) that declares a reflection.
- CNT_W, 16: counter width. SETTLE_CYCLES, SAMPLE_CYCLES and THRESHOLD must each be >= 1 and < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run measurements continuously while high.
- sensor_in  in  1  raw phototransistor level, asynchronous to clk; 1 = light received.
- led_drive  out  1  IR LED drive, registered; 1 = LED on.
- detect  out  1  latest reflection decision; holds its value between updates.
- detect_valid  out  1  one-cycle pulse when detect is updated.
- ambient_fault  out  1  latest ambient-saturation flag, updated with detect.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - led_drive, detect, detect_valid, ambient_fault and busy are all 0.
  - Counters and both synchronizer flops are 0.
- Synchronizer: sensor_in passes through a 2-flop synchronizer; only the synchronized bit (s_sync) is counted.
- FSM states and transitions:
  - IDLE: led_drive=0. If enable=1, go to ON_SETTLE on the next edge.
  - ON_SETTLE: led_drive=1 for exactly SETTLE_CYCLES cycles, then ON_SAMPLE. on_cnt and off_cnt are cleared on entry.
  - ON_SAMPLE: led_drive=1 for exactly SAMPLE_CYCLES cycles. on_cnt increments by s_sync each cycle. Then OFF_SETTLE.
  - OFF_SETTLE: led_drive=0 for exactly SETTLE_CYCLES cycles, then OFF_SAMPLE.
  - OFF_SAMPLE: led_drive=0 for exactly SAMPLE_CYCLES cycles. off_cnt increments by s_sync each cycle. Then DECIDE.
  - DECIDE: exactly 1 cycle. On the edge leaving DECIDE:
    - detect <= (on_cnt >= off_cnt + THRESHOLD).
    - ambient_fault <= (off_cnt > SAMPLE_CYCLES/2), integer divide.
    - detect_valid <= 1 for the following cycle only.
    - Next state is ON_SETTLE if enable=1, else IDLE.
- Arithmetic:
  - The comparison is evaluated in CNT_W+1 bits, so off_cnt + THRESHOLD cannot wrap.
  - Counters never exceed SAMPLE_CYCLES and need no saturation logic.
- Period: continuous mode gives 2*SETTLE_CYCLES + 2*SAMPLE_CYCLES + 1 cycles between detect_valid pulses (133 with defaults).
- First-pulse latency: first detect_valid is 1 + 133 cycles after enable is sampled high in IDLE.
- Enable drop mid-measurement (any non-IDLE state other than DECIDE):
  - Next state is IDLE and led_drive goes to 0 on the next edge.
  - Counts are discarded; no detect_valid.
  - detect and ambient_fault keep their previous values.
- Enable low during DECIDE: the measurement completes and publishes, then the FSM goes to IDLE.
- Re-enable always starts a full fresh measurement at ON_SETTLE.
- Reset mid-operation: everything returns to reset values immediately, including detect.
- busy is combinational from state (state != IDLE) and must not glitch across the DECIDE->ON_SETTLE transition.

Test Plan:
All cases use default parameters.
1. Reset: hold rst_n=0 with enable=1 and toggling sensor_in -> all outputs 0. After release, first led_drive=1 occurs 1 cycle after enable is sampled.
2. Reflective surface: sensor_in = led_drive, delayed 3 cycles -> on_cnt=16, off_cnt=0. Result: detect=1, ambient_fault=0, detect_valid pulses every 133 cycles.
3. Dark surface: sensor_in=0 constantly -> detect=0, ambient_fault=0, pulses continue every 133 cycles.
4. Saturating ambient: sensor_in=1 constantly -> on=16, off=16. Result: detect=0, ambient_fault=1. Then with off-phase ones = 8 -> ambient_fault=0; with 9 -> ambient_fault=1.
5. Threshold boundary, off_cnt=0:
   - 11 ones in ON_SAMPLE -> detect=0.
   - 12 ones -> detect=1.
   - 12 on / 1 off -> detect=0.
6. Abort and re-enable:
   - Drop enable in cycle 5 of ON_SAMPLE -> IDLE next cycle, led_drive=0, no detect_valid, detect holds its prior 1.
   - Reassert enable -> next detect_valid 134 cycles later.
   - Assert rst_n=0 in OFF_SETTLE -> detect=0 immediately.

Source files
------------

// File: rtl/ir_reflect_emitter.sv
// IR emitter pulse/sample sequencer: lights the LED, counts the synchronized
// phototransistor return in LED-on and LED-off windows, and publishes a reflection decision.
module ir_reflect_emitter #(
  parameter int SETTLE_CYCLES = 50,
  parameter int SAMPLE_CYCLES = 16,
  parameter int THRESHOLD     = 12,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sensor_in,
  output logic led_drive,
  output logic detect,
  output logic detect_valid,
  output logic ambient_fault,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ON_SETTLE  = 3'd1,
    ON_SAMPLE  = 3'd2,
    OFF_SETTLE = 3'd3,
    OFF_SAMPLE = 3'd4,
    DECIDE     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAULT_LIM   = CNT_W'(SAMPLE_CYCLES / 2);
  localparam logic [CNT_W:0]   THRESH_EXT  = (CNT_W + 1)'(THRESHOLD);

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
  logic             led_q, led_d;
  logic             detect_q, detect_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] s_inc;

  assign s_inc = {{(CNT_W-1){1'b0}}, sync2_q};

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 1'b1;
    on_cnt_d  = on_cnt_q;
    off_cnt_d = off_cnt_q;
    detect_d  = detect_q;
    fault_d   = fault_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (enable) begin
          state_d   = ON_SETTLE;
          on_cnt_d  = '0;
          off_cnt_d = '0;
        end
      end
      ON_SETTLE: begin
        if (!enable)                  state_d = IDLE;
        else if (tmr_q == SETTLE_LAST) state_d = ON_SAMPLE;
      end
      ON_SAMPLE: begin
        on_cnt_d = on_cnt_q + s_inc;
        if (!enable)                  state_d = IDLE;
        else if (tmr_q == SAMPLE_LAST) state_d = OFF_SETTLE;
      end
      OFF_SETTLE: begin
        if (!enable)                  state_d = IDLE;
        else if (tmr_q == SETTLE_LAST) state_d = OFF_SAMPLE;
      end
      OFF_SAMPLE: begin
        off_cnt_d = off_cnt_q + s_inc;
        if (!enable)                  state_d = IDLE;
        else if (tmr_q == SAMPLE_LAST) state_d = DECIDE;
      end
      DECIDE: begin
        // Extra MSB keeps off_cnt + THRESHOLD from wrapping.
        detect_d = ({1'b0, on_cnt_q} >= ({1'b0, off_cnt_q} + THRESH_EXT));
        fault_d  = (off_cnt_q > FAULT_LIM);
        valid_d  = 1'b1;
        if (enable) begin
          state_d   = ON_SETTLE;
          on_cnt_d  = '0;
          off_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) tmr_d = '0;

    // LED and busy are registered from next state so both are glitch-free.
    led_d  = (state_d == ON_SETTLE) || (state_d == ON_SAMPLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      tmr_q     <= '0;
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      led_q     <= 1'b0;
      detect_q  <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sensor_in;
      sync2_q   <= sync1_q;
      tmr_q     <= tmr_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      led_q     <= led_d;
      detect_q  <= detect_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
    end
  end

  assign led_drive     = led_q;
  assign detect        = detect_q;
  assign detect_valid  = valid_q;
  assign ambient_fault = fault_q;
  assign busy          = busy_q;

endmodule
